// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared definitions for the SPI host request queue: command
//               codes, packed stream-word field offsets, the queue FSM state
//               type and a helper that builds a stream word from a request.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam logic [3:0] CMD_READ  = 4'b1011;
    localparam logic [3:0] CMD_WRITE = 4'b1010;

    // Packed word layout: {cmd[3:0], addr[3:0], len[7:0], wdata[15:0]}
    localparam int CMD_LSB   = 28;
    localparam int ADDR_LSB  = 24;
    localparam int LEN_LSB   = 16;
    localparam int WDATA_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // len field carries the bit count (len_minus_one + 1); reads never carry
    // write data so the controller sees a clean zero payload.
    function automatic logic [31:0] pack_req(
        input logic        is_rd,
        input logic [3:0]  addr,
        input logic [3:0]  len_m1,
        input logic [15:0] wdata
    );
        logic [7:0] w_len;
        w_len    = {4'b0000, len_m1} + 8'd1;
        pack_req = {(is_rd ? CMD_READ : CMD_WRITE), addr, w_len,
                    (is_rd ? 16'h0000 : wdata)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spi_req_fifo
// Description : Synchronous DEPTH x WIDTH FIFO. Push is ignored when full,
//               pop is ignored when empty, push+pop together keep the level.
//               The head entry is read straight from flop storage, so it is
//               valid in the same cycle the FIFO reports non-empty.
// Ports       : clk_i, rst_n_i (sync, active-low)
//               push_i/din_i      - write side
//               pop_i/head_o      - read side (head_o = oldest entry)
//               full_o/empty_o    - status
//               level_o           - number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module spi_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);
    localparam logic [PTR_W:0]   c_lvl_one = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   c_lvl_max = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_level;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_level == c_lvl_max);
    assign empty_o = (r_level == '0);
    assign level_o = r_level;
    assign head_o  = r_mem[r_rd_ptr];

    assign w_push = push_i && !full_o;
    assign w_pop  = pop_i && !empty_o;

    // Pointers are exactly PTR_W bits wide, so they wrap modulo DEPTH.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_lvl_one;
                2'b01:   r_level <= r_level - c_lvl_one;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed once pushed.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= din_i;
    end

endmodule
`default_nettype wire

// File: rtl/spi_req_queue.sv
`default_nettype none
// ============================================================================
// Module      : spi_req_queue
// Description : Host-side request queue in front of the SPI master. Packs
//               read/write requests into 32-bit stream words, buffers them,
//               issues them one at a time and returns one tagged response
//               per request.
// Config      : SPI_REQ_QUEUE_TIMEOUT_EN - when defined, a WAIT watchdog of
//               TIMEOUT_CYCLES cycles ends a stuck transfer with rsp_err_o=1.
//               When undefined, rsp_err_o is tied low and WAIT never expires.
// Ports       : clk_i, rst_n_i (sync, active-low)
//               req_*      - host request (valid/ready)
//               spi_req_*  - packed word to the controller (valid/ready)
//               spi_rx_*   - controller read data (valid/ready), spi_eot_i
//               rsp_*      - tagged response to the host (valid/ready)
//               fifo_level_o - queued request count
// Revision    : 1.0 - initial release
// ============================================================================
module spi_req_queue
    import spi_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   req_vld_i,
    output logic                   req_rdy_o,
    input  logic                   req_is_rd_i,
    input  logic [3:0]             req_addr_i,
    input  logic [3:0]             req_len_i,
    input  logic [15:0]            req_wdata_i,
    input  logic [TAG_W-1:0]       req_tag_i,
    output logic [31:0]            spi_req_o,
    output logic                   spi_req_vld_o,
    input  logic                   spi_req_rdy_i,
    input  logic [31:0]            spi_rx_data_i,
    input  logic                   spi_rx_vld_i,
    output logic                   spi_rx_rdy_o,
    input  logic                   spi_eot_i,
    output logic                   rsp_vld_o,
    input  logic                   rsp_rdy_i,
    output logic [TAG_W-1:0]       rsp_tag_o,
    output logic                   rsp_is_rd_o,
    output logic [15:0]            rsp_rdata_o,
    output logic                   rsp_err_o,
    output logic [$clog2(DEPTH):0] fifo_level_o
);

    localparam int ENTRY_W = 32 + TAG_W;

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT_CYCLES < 2)) begin : g_bad_params
            $error("spi_req_queue: DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 2");
        end
    endgenerate

    state_t             r_state;
    logic [TAG_W-1:0]   r_cur_tag;
    logic               r_is_rd;
    logic               r_got_rx;
    logic               r_got_eot;
    logic [15:0]        r_rx_data;

    logic [ENTRY_W-1:0] w_push_entry;
    logic [ENTRY_W-1:0] w_head;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_head_is_rd;
    logic               w_rx_now;
    logic               w_done;
    logic               w_timeout;
    logic [15:0]        w_rdata;
    logic               w_unused;

    // ---------------- request packing and FIFO ----------------
    assign w_push_entry = {req_tag_i, pack_req(req_is_rd_i, req_addr_i, req_len_i, req_wdata_i)};
    assign req_rdy_o    = !w_full;
    assign w_push       = req_vld_i && req_rdy_o;
    assign w_pop        = (r_state == ISSUE) && spi_req_rdy_i;
    assign w_head_is_rd = (w_head[CMD_LSB +: 4] == CMD_READ);

    spi_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (w_push),
        .din_i   (w_push_entry),
        .pop_i   (w_pop),
        .head_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (fifo_level_o)
    );

    // ---------------- completion ----------------
    // rx and eot may arrive in either order or together, so the current
    // cycle's inputs are OR-ed with the sticky flags.
    assign w_rx_now = spi_rx_vld_i && spi_rx_rdy_o;
    assign w_done   = (r_state == WAIT) && (r_got_eot || spi_eot_i) &&
                      (!r_is_rd || r_got_rx || w_rx_now);
    // First accepted rx word wins; a later one in the same transfer is dropped.
    assign w_rdata  = r_got_rx ? r_rx_data : spi_rx_data_i[15:0];

    // Only the low half of the right-justified rx word is returned.
    assign w_unused = &{1'b0, spi_rx_data_i[31:16]};

`ifdef SPI_REQ_QUEUE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] c_tmo_one  = TMO_W'(1);
    logic [TMO_W-1:0] r_tmo_cnt;

    assign w_timeout = (r_state == WAIT) && !w_done && (r_tmo_cnt == c_tmo_last);
`else
    assign w_timeout = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

    // ---------------- control FSM ----------------
    // All interface outputs are registered: each transition loads the
    // values the next state must present.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state       <= IDLE;
            spi_req_o     <= '0;
            spi_req_vld_o <= 1'b0;
            spi_rx_rdy_o  <= 1'b0;
            rsp_vld_o     <= 1'b0;
            rsp_tag_o     <= '0;
            rsp_is_rd_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            r_cur_tag     <= '0;
            r_is_rd       <= 1'b0;
            r_got_rx      <= 1'b0;
            r_got_eot     <= 1'b0;
            r_rx_data     <= '0;
`ifdef SPI_REQ_QUEUE_TIMEOUT_EN
            rsp_err_o     <= 1'b0;
            r_tmo_cnt     <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    // Keep draining stale rx words while idle.
                    spi_rx_rdy_o <= 1'b1;
                    if (!w_empty) begin
                        r_state       <= ISSUE;
                        spi_req_o     <= w_head[31:0];
                        spi_req_vld_o <= 1'b1;
                        spi_rx_rdy_o  <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (spi_req_rdy_i) begin
                        r_state       <= WAIT;
                        spi_req_vld_o <= 1'b0;
                        spi_rx_rdy_o  <= 1'b1;
                        r_cur_tag     <= w_head[32 +: TAG_W];
                        r_is_rd       <= w_head_is_rd;
                        r_got_rx      <= 1'b0;
                        r_got_eot     <= 1'b0;
`ifdef SPI_REQ_QUEUE_TIMEOUT_EN
                        r_tmo_cnt     <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (spi_eot_i) r_got_eot <= 1'b1;
                    if (w_rx_now && r_is_rd && !r_got_rx) begin
                        r_got_rx  <= 1'b1;
                        r_rx_data <= spi_rx_data_i[15:0];
                    end
`ifdef SPI_REQ_QUEUE_TIMEOUT_EN
                    r_tmo_cnt <= r_tmo_cnt + c_tmo_one;
`endif
                    if (w_done || w_timeout) begin
                        r_state      <= RESP;
                        spi_rx_rdy_o <= 1'b0;
                        rsp_vld_o    <= 1'b1;
                        rsp_tag_o    <= r_cur_tag;
                        rsp_is_rd_o  <= r_is_rd;
                        rsp_rdata_o  <= (r_is_rd && w_done) ? w_rdata : 16'h0000;
`ifdef SPI_REQ_QUEUE_TIMEOUT_EN
                        rsp_err_o    <= !w_done;
`endif
                    end
                end
                RESP: begin
                    if (rsp_rdy_i) begin
                        r_state      <= IDLE;
                        rsp_vld_o    <= 1'b0;
                        spi_rx_rdy_o <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_req_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_req_queue
// Description : Directed self-checking bench for spi_req_queue with
//               hand-computed expected stream words and responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_req_queue;

    localparam int DEPTH          = 4;
    localparam int TAG_W          = 4;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int LVL_W          = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_vld, req_rdy, req_is_rd;
    logic [3:0]        req_addr, req_len;
    logic [15:0]       req_wdata;
    logic [TAG_W-1:0]  req_tag;
    logic [31:0]       spi_req;
    logic              spi_req_vld, spi_req_rdy;
    logic [31:0]       spi_rx_data;
    logic              spi_rx_vld, spi_rx_rdy, spi_eot;
    logic              rsp_vld, rsp_rdy, rsp_is_rd, rsp_err;
    logic [TAG_W-1:0]  rsp_tag;
    logic [15:0]       rsp_rdata;
    logic [LVL_W-1:0]  level;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    spi_req_queue #(
        .DEPTH          (DEPTH),
        .TAG_W          (TAG_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .req_vld_i     (req_vld),
        .req_rdy_o     (req_rdy),
        .req_is_rd_i   (req_is_rd),
        .req_addr_i    (req_addr),
        .req_len_i     (req_len),
        .req_wdata_i   (req_wdata),
        .req_tag_i     (req_tag),
        .spi_req_o     (spi_req),
        .spi_req_vld_o (spi_req_vld),
        .spi_req_rdy_i (spi_req_rdy),
        .spi_rx_data_i (spi_rx_data),
        .spi_rx_vld_i  (spi_rx_vld),
        .spi_rx_rdy_o  (spi_rx_rdy),
        .spi_eot_i     (spi_eot),
        .rsp_vld_o     (rsp_vld),
        .rsp_rdy_i     (rsp_rdy),
        .rsp_tag_o     (rsp_tag),
        .rsp_is_rd_o   (rsp_is_rd),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_err_o     (rsp_err),
        .fifo_level_o  (level)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic is_rd, input logic [3:0] addr, input logic [3:0] len,
                        input logic [15:0] wdata, input logic [3:0] tag);
        req_vld   = 1'b1;
        req_is_rd = is_rd;
        req_addr  = addr;
        req_len   = len;
        req_wdata = wdata;
        req_tag   = tag;
        tick();
        req_vld   = 1'b0;
    endtask

    // Wait (bounded) for the packed word, check it, then grant it.
    task automatic issue(input string name, input logic [31:0] exp_word);
        for (int i = 0; i < 20 && !spi_req_vld; i++) tick();
        check({name, "_req_vld"}, 32'(spi_req_vld), 32'd1);
        check({name, "_req_word"}, spi_req, exp_word);
        spi_req_rdy = 1'b1;
        tick();
        spi_req_rdy = 1'b0;
    endtask

    task automatic send_rx(input logic [31:0] data);
        spi_rx_data = data;
        spi_rx_vld  = 1'b1;
        tick();
        spi_rx_vld  = 1'b0;
    endtask

    task automatic send_eot();
        spi_eot = 1'b1;
        tick();
        spi_eot = 1'b0;
    endtask

    // Wait (bounded) for the response, check all fields, then accept it.
    task automatic finish_rsp(input string name, input logic [3:0] tag, input logic is_rd,
                              input logic [15:0] rdata, input logic err);
        for (int i = 0; i < 40 && !rsp_vld; i++) tick();
        check({name, "_rsp_vld"}, 32'(rsp_vld), 32'd1);
        check({name, "_rsp_tag"}, 32'(rsp_tag), 32'(tag));
        check({name, "_rsp_is_rd"}, 32'(rsp_is_rd), 32'(is_rd));
        check({name, "_rsp_rdata"}, 32'(rsp_rdata), 32'(rdata));
        check({name, "_rsp_err"}, 32'(rsp_err), 32'(err));
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;
        check({name, "_rsp_drop"}, 32'(rsp_vld), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n = 1'b0; req_vld = 1'b0; req_is_rd = 1'b0; req_addr = '0; req_len = '0;
        req_wdata = '0; req_tag = '0; spi_req_rdy = 1'b0; spi_rx_data = '0;
        spi_rx_vld = 1'b0; spi_eot = 1'b0; rsp_rdy = 1'b0;
        repeat (3) tick();

        // ---------------- reset values ----------------
        check("rst_req_rdy",   32'(req_rdy),     32'd1);
        check("rst_level",     32'(level),       32'd0);
        check("rst_req_vld",   32'(spi_req_vld), 32'd0);
        check("rst_rx_rdy",    32'(spi_rx_rdy),  32'd0);
        check("rst_rsp_vld",   32'(rsp_vld),     32'd0);
        check("rst_spi_req",   spi_req,          32'd0);
        check("rst_rsp_fields", {10'd0, rsp_is_rd, rsp_err, rsp_tag, rsp_rdata}, 32'd0);
        rst_n = 1'b1;
        tick();

        // ---------------- write, latency N+2 ----------------
        push(1'b0, 4'd3, 4'd15, 16'hA55A, 4'd2);
        check("t1_lat_n1_vld", 32'(spi_req_vld), 32'd0);
        check("t1_level1",     32'(level),       32'd1);
        tick();
        check("t1_lat_n2_vld", 32'(spi_req_vld), 32'd1);
        issue("t1", 32'hA310A55A);
        check("t1_level0", 32'(level), 32'd0);
        send_rx(32'h0000BEEF);             // rx during a write is ignored
        check("t1_no_rsp_before_eot", 32'(rsp_vld), 32'd0);
        send_eot();
        check("t1_rsp_latency", 32'(rsp_vld), 32'd1);
        finish_rsp("t1", 4'd2, 1'b0, 16'h0000, 1'b0);

        // ---------------- read, rx before eot ----------------
        push(1'b1, 4'd5, 4'd7, 16'h1234, 4'd6);
        issue("t2", 32'hB5080000);
        send_rx(32'h000000C3);
        check("t2_wait_eot", 32'(rsp_vld), 32'd0);
        send_eot();
        check("t2_rsp_latency", 32'(rsp_vld), 32'd1);
        finish_rsp("t2", 4'd6, 1'b1, 16'h00C3, 1'b0);

        // ---------------- read, eot before rx ----------------
        push(1'b1, 4'd5, 4'd7, 16'h0000, 4'd7);
        issue("t3", 32'hB5080000);
        send_eot();
        check("t3_wait_rx", 32'(rsp_vld), 32'd0);
        send_rx(32'hFFFF00C3);
        check("t3_rsp_latency", 32'(rsp_vld), 32'd1);
        finish_rsp("t3", 4'd7, 1'b1, 16'h00C3, 1'b0);

        // ---------------- read, rx and eot together ----------------
        push(1'b1, 4'd9, 4'd0, 16'hFFFF, 4'd3);
        issue("t3b", 32'hB9010000);
        spi_rx_data = 32'h5A5A1234;
        spi_rx_vld  = 1'b1;
        spi_eot     = 1'b1;
        tick();
        spi_rx_vld  = 1'b0;
        spi_eot     = 1'b0;
        check("t3b_rsp_latency", 32'(rsp_vld), 32'd1);
        finish_rsp("t3b", 4'd3, 1'b1, 16'h1234, 1'b0);

        // ---------------- fill FIFO with controller stalled ----------------
        push(1'b0, 4'd0, 4'd0, 16'h0001, 4'd8);
        push(1'b1, 4'd15, 4'd15, 16'h0000, 4'd9);
        push(1'b0, 4'd7, 4'd3, 16'hFFFF, 4'd10);
        push(1'b1, 4'd1, 4'd1, 16'h0000, 4'd11);
        check("t4_full_rdy",   32'(req_rdy), 32'd0);
        check("t4_full_level", 32'(level),   32'd4);
        push(1'b0, 4'd2, 4'd2, 16'h2222, 4'd12);   // refused: queue full
        check("t4_overflow_level", 32'(level), 32'd4);
        check("t4_head_stable", spi_req, 32'hA0010001);

        issue("t4_0", 32'hA0010001);
        check("t4_level_after_pop", 32'(level), 32'd3);
        send_eot();
        // Hold the response for 10 cycles: fields stable, nothing issued.
        for (int i = 0; i < 10; i++) begin
            check("t4_hold", 32'({rsp_vld, rsp_tag, rsp_is_rd, rsp_rdata, spi_req_vld}),
                  32'({1'b1, 4'd8, 1'b0, 16'h0000, 1'b0}));
            tick();
        end
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;
        check("t4_idle_after_hs", 32'({rsp_vld, spi_req_vld}), 32'd0);
        tick();
        check("t4_issue_after_idle", 32'(spi_req_vld), 32'd1);

        issue("t4_1", 32'hBF100000);
        send_rx(32'h00001111);
        send_eot();
        finish_rsp("t4_1", 4'd9, 1'b1, 16'h1111, 1'b0);
        issue("t4_2", 32'hA704FFFF);
        send_eot();
        finish_rsp("t4_2", 4'd10, 1'b0, 16'h0000, 1'b0);
        issue("t4_3", 32'hB1020000);
        send_rx(32'h0000ABCD);
        send_eot();
        finish_rsp("t4_3", 4'd11, 1'b1, 16'hABCD, 1'b0);
        check("t4_empty", 32'(level), 32'd0);

        // ---------------- reset during WAIT ----------------
        push(1'b0, 4'd2, 4'd2, 16'h0F0F, 4'd5);
        push(1'b1, 4'd4, 4'd4, 16'h0000, 4'd13);
        issue("t6", 32'hA2030F0F);
        check("t6_level_before_rst", 32'(level), 32'd1);
        rst_n = 1'b0;
        tick();
        check("t6_rst_outputs", 32'({spi_req_vld, spi_rx_rdy, rsp_vld, rsp_is_rd, rsp_err}), 32'd0);
        check("t6_rst_level",   32'({req_rdy, level}), 32'({1'b1, 3'd0}));
        check("t6_rst_spi_req", spi_req, 32'd0);
        check("t6_rst_rsp",     32'({rsp_tag, rsp_rdata}), 32'd0);
        rst_n = 1'b1;
        send_eot();
        repeat (4) tick();
        check("t6_no_activity", 32'({rsp_vld, spi_req_vld}), 32'd0);
        check("t6_idle_rx_rdy", 32'(spi_rx_rdy), 32'd1);

        // ---------------- watchdog ----------------
        push(1'b1, 4'd6, 4'd3, 16'h0000, 4'd14);
        issue("t7", 32'hB6040000);
`ifdef SPI_REQ_QUEUE_TIMEOUT_EN
        k = 0;
        while (!rsp_vld && k < 40) begin
            tick();
            k++;
        end
        check("t7_timeout_cycles", 32'(k), 32'd16);
        finish_rsp("t7", 4'd14, 1'b1, 16'h0000, 1'b1);
        send_rx(32'h00007777);
        send_eot();
        repeat (3) tick();
        check("t7_late_ignored", 32'({rsp_vld, spi_req_vld}), 32'd0);
        push(1'b0, 4'd1, 4'd0, 16'h00AA, 4'd1);
        issue("t7b", 32'hA10100AA);
        send_eot();
        finish_rsp("t7b", 4'd1, 1'b0, 16'h0000, 1'b0);
`else
        k = 0;
        repeat (30) begin
            tick();
            if (rsp_vld) k++;
        end
        check("t7_no_timeout", 32'(k), 32'd0);
        send_rx(32'h00007777);
        send_eot();
        finish_rsp("t7", 4'd14, 1'b1, 16'h7777, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
